// File: rtl/rf_pkg.sv
// Shared types and helpers for the multi-port register file.
// The state encoding and the byte-lane merge are common to the init controller and the datapath.
package rf_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } rf_state_e;

  localparam int unsigned BYTE_W = 8;

  function automatic int unsigned bytes_of(input int unsigned data_w);
    return data_w / BYTE_W;
  endfunction

  // One byte lane of a byte-enabled write: the enabled lane takes new data, others keep old.
  function automatic logic [BYTE_W-1:0] byte_merge(input logic             be,
                                                   input logic [BYTE_W-1:0] new_b,
                                                   input logic [BYTE_W-1:0] old_b);
    return be ? new_b : old_b;
  endfunction

endpackage

// File: rtl/rf_init_ctrl.sv
// Hardware clear sequencer: after reset walks clr_ptr over every entry, one per clock,
// then enters RUN and raises ready.
module rf_init_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  output logic              o_ready,
  output logic              o_clr_we,
  output logic [ADDR_W-1:0] o_clr_addr
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  rf_state_e         r_state;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_ready;
  logic              r_clr_we;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= ST_INIT;
      r_clr_ptr <= '0;
      r_ready   <= 1'b0;
      r_clr_we  <= 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_clr_ptr <= r_clr_ptr + 1'b1;
          // Terminal compare against DEPTH-1 so a short file never wraps the pointer.
          if (r_clr_ptr == LAST) begin
            r_state   <= ST_RUN;
            r_ready   <= 1'b1;
            r_clr_we  <= 1'b0;
            r_clr_ptr <= '0;
          end
        end
        ST_RUN: begin
          r_ready  <= 1'b1;
          r_clr_we <= 1'b0;
        end
        default: begin
          r_state   <= ST_INIT;
          r_clr_ptr <= '0;
          r_ready   <= 1'b0;
          r_clr_we  <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready    = r_ready;
  assign o_clr_we   = r_clr_we;
  assign o_clr_addr = r_clr_ptr;

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised register file: NUM_RD combinational read ports, one byte-enabled write port,
// optional write-to-read bypass and hardwired zero entry; contents cleared by rf_init_ctrl.
module reg_file_mp
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 32,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_waddr,
  input  logic [DATA_W-1:0]        i_wdata,
  input  logic [DATA_W/8-1:0]      i_wbe,
  input  logic [NUM_RD*ADDR_W-1:0] i_raddr,
  output logic [NUM_RD*DATA_W-1:0] o_rdata,
  output logic                     o_ready
);

  localparam int unsigned BYTES = bytes_of(DATA_W);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_ready;
  logic              w_clr_we;
  logic [ADDR_W-1:0] w_clr_addr;
  logic [IDX_W-1:0]  w_cidx;
  logic [IDX_W-1:0]  w_widx;
  logic              w_wvalid;
  logic              w_wzero;
  logic              w_user_we;
  logic [DATA_W-1:0] w_old;
  logic [DATA_W-1:0] w_merged;

  rf_init_ctrl #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_init_ctrl (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .o_ready    (w_ready),
    .o_clr_we   (w_clr_we),
    .o_clr_addr (w_clr_addr)
  );

  assign w_cidx    = w_clr_addr[IDX_W-1:0];
  assign w_widx    = i_waddr[IDX_W-1:0];
  assign w_wvalid  = ({1'b0, i_waddr} < DEPTH_L);
  assign w_wzero   = (ZERO_REG != 0) && (i_waddr == '0);
  assign w_user_we = w_ready && i_we && w_wvalid && !w_wzero;

  // Post-write value of the addressed entry; feeds both the array and the bypass path.
  always_comb begin
    w_old    = w_wvalid ? r_mem[w_widx] : '0;
    w_merged = '0;
    for (int b = 0; b < int'(BYTES); b++) begin
      w_merged[b*BYTE_W +: BYTE_W] = byte_merge(i_wbe[b], i_wdata[b*BYTE_W +: BYTE_W],
                                                w_old[b*BYTE_W +: BYTE_W]);
    end
  end

  // The clear sequence owns the array during INIT; user writes only land once ready.
  always_ff @(posedge i_clk) begin
    if (w_clr_we) begin
      r_mem[w_cidx] <= '0;
    end else if (w_user_we) begin
      r_mem[w_widx] <= w_merged;
    end
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [ADDR_W-1:0] w_ra;
    logic [IDX_W-1:0]  w_ridx;
    logic              w_rvalid;
    logic              w_rzero;
    logic              w_hit;
    logic [DATA_W-1:0] w_rd;

    assign w_ra     = i_raddr[k*ADDR_W +: ADDR_W];
    assign w_ridx   = w_ra[IDX_W-1:0];
    assign w_rvalid = ({1'b0, w_ra} < DEPTH_L);
    assign w_rzero  = (ZERO_REG != 0) && (w_ra == '0);
    assign w_hit    = (BYPASS != 0) && w_user_we && (w_ra == i_waddr);

    always_comb begin
      w_rd = '0;
      if (w_ready && w_rvalid && !w_rzero) begin
        w_rd = w_hit ? w_merged : r_mem[w_ridx];
      end
    end

    assign o_rdata[k*DATA_W +: DATA_W] = w_rd;
  end

  assign o_ready = w_ready;

endmodule
